// File: rtl/lu_pkg.sv
// Shared opcode and FSM encodings for the bit-serial logic-unit sequencer.
package lu_pkg;

   localparam logic [1:0] LU_NOR  = 2'b00;
   localparam logic [1:0] LU_OR   = 2'b01;
   localparam logic [1:0] LU_NAND = 2'b10;
   localparam logic [1:0] LU_AND  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lu_bit_slice.sv
// 1-bit AND/OR/NAND/NOR logic unit; purely combinational, no backpressure.
// op[0] picks the non-inverted (AND/OR) group, op[1] picks AND-type within a group.
module lu_bit_slice
   import lu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic [1:0] i_op,
   output logic       o_y
);

   logic w_and;
   logic w_or;
   logic w_nand;
   logic w_nor;
   logic w_pos_grp;
   logic w_neg_grp;

   assign w_and     = i_a & i_b;
   assign w_or      = i_a | i_b;
   assign w_nand    = ~w_and;
   assign w_nor     = ~w_or;

   assign w_pos_grp = i_op[1] ? w_and  : w_or;
   assign w_neg_grp = i_op[1] ? w_nand : w_nor;
   assign o_y       = i_op[0] ? w_pos_grp : w_neg_grp;

endmodule

// File: rtl/lu_serial_sequencer.sv
// Bit-serial word logic op through one shared slice; result valid WIDTH cycles after accept.
// cmd_ready only in IDLE; result held in DONE until res_ready, so a stalled sink stalls commands.
module lu_serial_sequencer
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_cnt;
   logic             w_y;
   logic             w_accept;
   logic             w_step;

   lu_bit_slice u_slice (
      .i_a  (r_a_sh[0]),
      .i_b  (r_b_sh[0]),
      .i_op (r_op),
      .o_y  (w_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      res_valid   = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == LP_LAST) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Result enters at the MSB so that after WIDTH shifts bit i lines up with operand bit i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= LU_NOR;
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_res  <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_op   <= cmd_op;
         r_a_sh <= cmd_a;
         r_b_sh <= cmd_b;
         r_res  <= '0;
         r_cnt  <= '0;
      end else if (w_step) begin
         r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_res  <= {w_y, r_res[WIDTH-1:1]};
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   assign res_data = r_res;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Scoreboard bench: handshakes push expected words from a word-level model; monitors pop on result transfer.
module tb_lu_serial_sequencer;
   import lu_pkg::*;

   localparam int W  = 8;
   localparam int W2 = 2;

   typedef struct {
      logic [31:0] data;
      int          acc;
   } exp_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [W-1:0]  cmd_a = '0;
   logic [W-1:0]  cmd_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  res_data;
   logic          busy;

   logic          c2_valid = 1'b0;
   logic          c2_ready;
   logic [1:0]    c2_op = 2'b00;
   logic [W2-1:0] c2_a = '0;
   logic [W2-1:0] c2_b = '0;
   logic          r2_valid;
   logic          r2_ready = 1'b1;
   logic [W2-1:0] r2_data;
   logic          busy2;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t q8[$];
   exp_t q2[$];
   int   acc_q[$];
   int   n_acc8 = 0;
   int   n_xfer8 = 0;
   bit   seen8 = 0;
   bit   seen2 = 0;
   logic [W-1:0] hold8;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   lu_serial_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   lu_serial_sequencer #(.WIDTH(W2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(c2_op),
      .cmd_a(c2_a), .cmd_b(c2_b),
      .res_valid(r2_valid), .res_ready(r2_ready), .res_data(r2_data),
      .busy(busy2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word-wide reference: the logic op applied to whole operands, masked to w bits.
   function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
      logic [31:0] r;
      logic [31:0] m;
      m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case (op)
         LU_NOR:  r = ~(a | b);
         LU_OR:   r = a | b;
         LU_NAND: r = ~(a & b);
         default: r = a & b;
      endcase
      return r & m;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid && cmd_ready) begin
            q8.push_back('{ref_op(cmd_op, 32'(cmd_a), 32'(cmd_b), W), cyc + 1});
            acc_q.push_back(cyc + 1);
            n_acc8++;
         end
         if (res_valid) begin
            check("done_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
            if (q8.size() == 0) begin
               check("spurious_res_valid", 32'd1, 32'd0);
            end else begin
               if (!seen8) begin
                  check("latency8", 32'(cyc - q8[0].acc), W);
                  hold8 = res_data;
                  seen8 = 1;
               end else begin
                  check("hold_stable", 32'(res_data), 32'(hold8));
               end
               if (res_ready) begin
                  check("res_data8", 32'(res_data), q8[0].data);
                  void'(q8.pop_front());
                  seen8 = 0;
                  n_xfer8++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (c2_valid && c2_ready)
            q2.push_back('{ref_op(c2_op, 32'(c2_a), 32'(c2_b), W2), cyc + 1});
         if (r2_valid) begin
            if (q2.size() == 0) begin
               check("spurious_r2_valid", 32'd1, 32'd0);
            end else begin
               if (!seen2) begin
                  check("latency2", 32'(cyc - q2[0].acc), W2);
                  seen2 = 1;
               end
               if (r2_ready) begin
                  check("res_data2", 32'(r2_data), q2[0].data);
                  void'(q2.pop_front());
                  seen2 = 0;
               end
            end
         end
      end
   end

   task automatic send8(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout8", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain8(input bit rnd);
      int t = 0;
      while (q8.size() != 0 && t < 400) begin
         @(posedge clk); #1;
         if (rnd) res_ready = 1'($urandom_range(0, 1));
         t++;
      end
      if (q8.size() != 0) check("drain_timeout8", 32'd0, 32'd1);
   endtask

   task automatic send2(input logic [1:0] op, input logic [W2-1:0] a, input logic [W2-1:0] b);
      int t = 0;
      c2_op = op; c2_a = a; c2_b = b; c2_valid = 1'b1;
      @(negedge clk);
      while (!c2_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!c2_ready) check("accept_timeout2", 32'd0, 32'd1);
      @(posedge clk); #1;
      c2_valid = 1'b0;
      t = 0;
      while (q2.size() != 0 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (q2.size() != 0) check("drain_timeout2", 32'd0, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int xfer_before;

      #2 rst_n = 1'b0;
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data",  32'(res_data),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      res_ready = 1'b1;
      send8(LU_AND, 8'hF0, 8'h3C);
      drain8(0);
      check("idle_after_and", {30'd0, cmd_ready, busy}, 32'd2);
      send8(LU_NOR, 8'h0F, 8'h30);
      drain8(0);
      send8(LU_OR, 8'h0F, 8'h30);
      drain8(0);

      // NAND with a stalled consumer, then a command offered in the same cycle the result drains.
      res_ready = 1'b0;
      send8(LU_NAND, 8'hAA, 8'hFF);
      t = 0;
      while (!res_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("nand_valid_seen", 32'(res_valid), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("nand_still_valid", 32'(res_valid), 32'd1);
      check("nand_cmd_ready", 32'(cmd_ready), 32'd0);
      xfer_before = n_xfer8;
      cmd_op = LU_OR; cmd_a = 8'h12; cmd_b = 8'h34; cmd_valid = 1'b1;
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("nand_valid_dropped", 32'(res_valid), 32'd0);
      check("nand_one_xfer", 32'(n_xfer8 - xfer_before), 32'd1);
      check("no_accept_in_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      drain8(0);

      // cmd_valid held through RUN with operands changing every cycle.
      acc_q = {};
      cmd_op = 2'($urandom_range(0, 3)); cmd_a = W'($urandom); cmd_b = W'($urandom);
      cmd_valid = 1'b1;
      repeat (3 * (W + 2) + 1) begin
         @(posedge clk); #1;
         cmd_op = 2'($urandom_range(0, 3)); cmd_a = W'($urandom); cmd_b = W'($urandom);
      end
      cmd_valid = 1'b0;
      drain8(0);
      check("held_accept_count", 32'(acc_q.size() >= 3), 32'd1);
      for (int i = 1; i < acc_q.size(); i++)
         check("back_to_back_gap", 32'(acc_q[i] - acc_q[i-1]), W + 2);

      // Asynchronous reset in the middle of RUN.
      cmd_op = LU_AND; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_cmd_ready", 32'(cmd_ready), 32'd1);
      check("midrun_res_valid", 32'(res_valid), 32'd0);
      check("midrun_res_data",  32'(res_data),  32'd0);
      check("midrun_busy",      32'(busy),      32'd0);
      n_acc8 = n_acc8 - q8.size();
      q8 = {};
      seen8 = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send8(LU_AND, 8'hFF, 8'h81);
      drain8(0);

      for (int n = 0; n < 40; n++) begin
         res_ready = 1'($urandom_range(0, 1));
         send8(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         drain8(1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      res_ready = 1'b1;

      for (int op = 0; op < 4; op++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
               send2(2'(op), 2'(a), 2'(b));

      check("queue8_empty", 32'(q8.size()), 32'd0);
      check("accepts_eq_xfers", 32'(n_acc8), 32'(n_xfer8));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
